score_seg_driver: RTL
=====================

// Module: score_seg_driver
// PURPOSE
//  Downstream consumer of the game score produced by the VGA/game logic.
//  Clamps the signed score to 0..9999, converts it to BCD with a multi-cycle
//  double-dabble sub-module, and time-multiplexes four active-low 7-segment
//  digits onto the board seg/an pins.
// PARAMETERS
//  SCORE_W       32     width of signed score input (two's complement)
//  REFRESH_BITS  16     digit dwell = 2**REFRESH_BITS i_clk cycles
// PORTS
//  i_clk     in   1        system clock (100 MHz board clock)
//  i_rst     in   1        synchronous, active-high reset
//  i_score   in   SCORE_W  signed score, sampled only at conversion start
//  o_seg     out  8        active-low segments: [0]=a..[6]=g, [7]=dp
//  o_an      out  4        active-low anodes, one-hot-low; [0]=rightmost digit
//  o_busy    out  1        high while a conversion is in flight
// BEHAVIOUR
//  Reset: o_seg=8'hFF, o_an=4'b1111, o_busy=0, display BCD=0000,
//   refresh counter=0, digit index=0, converter FSM=IDLE.
//  Clamp on capture: i_score<0 -> 0; i_score>9999 -> 9999; else unchanged (14 b).
//  Converter FSM: IDLE -> SHIFT (14 cycles) -> COMMIT -> IDLE.
//   IDLE: capture clamped i_score every cycle it is entered; o_busy=0.
//   SHIFT: per cycle add 3 to each BCD nibble >=5, then shift left 1; o_busy=1.
//   COMMIT: write 16-bit BCD into display register in one cycle (atomic; no
//    torn digits); o_busy=1.
//   Latency: capture to display register = 16 cycles; restarts immediately.
//  i_score changes during SHIFT/COMMIT are ignored until next capture.
//  Multiplexer: refresh counter wraps at 2**REFRESH_BITS-1; on wrap digit index
//   increments 0->1->2->3->0. o_an/o_seg registered, change same cycle as index.
//  o_an[k]=0 exactly when index==k (and digit not blanked); o_seg[7]=1 always.
//  Digit patterns 0-9 standard; nibble >9 (never expected) -> all segs off.
//  Reset mid-conversion: conversion aborted, display reverts to 0000.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading zero digits blanked (o_an stays 1
//   during their slot, o_seg=8'hFF); digit 0 always lit, so 0 shows as "   0".
//  Not defined: all four digits always lit, zero-padded ("0042").
// STRUCTURE
//  Shared include seg_defs.vh: NUM_DIGITS=4, SCORE_MAX=9999, BCD_BITS=16,
//   BIN_BITS=14, SEG_BLANK=8'hFF, SEG_DIGIT[0..9] pattern constants.
//  Sub-module bin2bcd_seq: clamp-free 14-bit -> 16-bit BCD double-dabble with
//   start/busy/done; score_seg_driver owns clamp, display register, mux.
// TESTING  (bench uses REFRESH_BITS=2)
//  Reset held 3 cycles -> o_an=1111, o_seg=FF; after release, first digit shows
//   "0" pattern (8'hC0) within 4 cycles on an=1110.
//  i_score=1234 steady -> within 16 cycles display BCD=16'h1234; an sweep
//   1110/1101/1011/0111 shows 4,3,2,1 with 4 cycles dwell each.
//  i_score=-5 -> 0000; i_score=12345 -> 9999 (clamp both ends).
//  i_score 42 -> 77 mid-SHIFT -> display goes 0042 then 0077, never a mix;
//   o_busy high exactly 15 cycles per conversion.
//  i_rst pulsed during SHIFT with i_score=9999 -> display 0000 next cycle,
//   then 9999 16 cycles after release.
//  LEADING_ZERO_BLANK_EN, i_score=7 -> only an=1110 ever low, seg=8'hF8;
//   i_score=0 -> digit 0 shows 8'hC0.

Source files
------------

// File: rtl/score_seg_driver_pkg.sv
// Shared constants, converter state type and the active-low 7-segment decoder
// for the score display driver.
package score_seg_driver_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         SCORE_MAX  = 9999;
    localparam int         BCD_BITS   = 16;
    localparam int         BIN_BITS   = 14;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_e;

    // Bit 0 = segment a ... bit 6 = g, bit 7 = dp (kept dark); 0 lights a segment.
    function automatic logic [7:0] seg_digit(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/score_seg_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 14-bit binary to 4-digit BCD.
// One capture cycle, 14 shift cycles, one commit cycle with done_o asserted.
module score_seg_driver_bin2bcd_seq
    import score_seg_driver_pkg::*;
(
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                start_i,
    input  logic [BIN_BITS-1:0] bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [BCD_BITS-1:0] bcd_o
);

    conv_state_e                  state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [BCD_BITS+BIN_BITS-1:0] sr_q, sr_d;
    logic [BCD_BITS-1:0]          adj;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib             = sr_q[BIN_BITS + 4*gi +: 4];
        assign adj[4*gi +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    sr_d    = {{BCD_BITS{1'b0}}, bin_i};
                    cnt_d   = '0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                busy_o = 1'b1;
                sr_d   = {adj, sr_q[BIN_BITS-1:0]} << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(BIN_BITS - 1)) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign bcd_o = sr_q[BIN_BITS +: BCD_BITS];

endmodule

// File: rtl/score_seg_driver.sv
// Score display driver: clamps the signed score to 0..9999, converts it to BCD
// and multiplexes four active-low digits. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module score_seg_driver
    import score_seg_driver_pkg::*;
#(
    parameter int SCORE_W      = 32,
    parameter int REFRESH_BITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SCORE_W-1:0] i_score,
    output logic [7:0]         o_seg,
    output logic [3:0]         o_an,
    output logic               o_busy
);

    localparam logic signed [SCORE_W-1:0] MAX_S = SCORE_W'(SCORE_MAX);

    logic [BIN_BITS-1:0]     clamped;
    logic                    conv_done;
    logic [BCD_BITS-1:0]     conv_bcd;
    logic [BCD_BITS-1:0]     disp_q, disp_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [1:0]              idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;
    logic [NUM_DIGITS-1:0]   lit;

    always_comb begin
        if (i_score[SCORE_W-1]) begin
            clamped = '0;
        end else if ($signed(i_score) > MAX_S) begin
            clamped = BIN_BITS'(SCORE_MAX);
        end else begin
            clamped = i_score[BIN_BITS-1:0];
        end
    end

    // Converter restarts as soon as it returns to idle, so the display tracks the score.
    score_seg_driver_bin2bcd_seq u_conv (
        .clk_i   (i_clk),
        .srst_i  (i_rst),
        .start_i (1'b1),
        .bin_i   (clamped),
        .busy_o  (o_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is lit if it is the units digit or any digit at or above it is non-zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lit
        if (gi == 0) begin : g_units
            assign lit[gi] = 1'b1;
        end else begin : g_upper
            assign lit[gi] = |disp_q[BCD_BITS-1:4*gi];
        end
    end
`else
    assign lit = '1;
`endif

    always_comb begin
        disp_d    = conv_done ? conv_bcd : disp_q;
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (&refresh_q) begin
            idx_d = idx_q + 2'd1;
        end
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (lit[idx_d]) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_digit(disp_q[4*idx_d +: 4]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            disp_q    <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'b1111;
        end else begin
            disp_q    <= disp_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign o_seg = seg_q;
    assign o_an  = an_q;

endmodule
